// File: rtl/int_ctrl_pkg.sv
// Purpose: shared definitions for the int_ctrl interrupt source: FSM state codes,
//          MMIO word indices and the CLAIM valid-bit position.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package int_ctrl_pkg;

  // State codes double as the STATUS register readback value.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // MMIO word indices on the CPU data bus.
  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // CLAIM bit that reports "a request or service is in flight".
  localparam int CLAIM_VLD_BIT = 31;

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// Purpose: two-flop synchroniser plus rising-edge detect for one raw request line.
// Latency: a line first sampled high at edge k gives rise=1 between edges k+1 and k+2.
// Backpressure: none; the line is sampled every cycle and a held level re-arms only after going low.
//
// Ports:
//   clk      in   system clock, rising edge
//   rstn     in   asynchronous active-low reset
//   async_in in   raw asynchronous request line
//   rise     out  one-cycle pulse on a synchronised 0->1 transition
module int_ctrl_irq_sync (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // A level held high produces exactly one pulse; it must drop low before it can fire again.
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Purpose: interrupt source for the sccomp CPU: latches edge requests, raises Int for the
//          lowest-index enabled pending source and tracks the ack / mret handshake.
// Latency: source edge at clk edge k -> pending at k+2 -> Int and int_id at k+3.
// Backpressure: only one request in flight; new requests wait in PENDING until the CPU
//               acks the current one and signals mret-done.
//
// Ports:
//   clk, rstn            clock (rising edge) and asynchronous active-low reset
//   irq_src[NSRC]        raw asynchronous request lines, rising edge = request
//   Int, int_id          registered interrupt request and its source ID
//   int_ack, int_done    CPU trap-entry and mret-done pulses
//   mmio_we/addr/wdata   MMIO write port (ENABLE, PENDING W1C, CLAIM, STATUS)
//   mmio_rdata           combinational readback of the addressed word
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NSRC-1:0] irq_src,
  output logic            Int,
  output logic [IDW-1:0]  int_id,
  input  logic            int_ack,
  input  logic            int_done,
  input  logic            mmio_we,
  input  logic [1:0]      mmio_addr,
  input  logic [31:0]     mmio_wdata,
  output logic [31:0]     mmio_rdata
);

  // ---------------------------------------------------------------------------
  // Per-line synchroniser / edge detect
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] rise;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    int_ctrl_irq_sync u_sync (
      .clk      (clk),
      .rstn     (rstn),
      .async_in (irq_src[g]),
      .rise     (rise[g])
    );
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            int_q, int_d;
  logic [IDW-1:0]  int_id_q, int_id_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] pending_q, pending_d;

  logic [NSRC-1:0] cand;
  logic [IDW-1:0]  winner;
  logic [NSRC-1:0] pend_clr;
  logic            wr_enable;
  logic            wr_pending;
  logic            ack_take;

  // Only the low NSRC bits of the write data are architecturally meaningful.
  logic unused_wdata;
  assign unused_wdata = ^mmio_wdata;

  assign wr_enable  = mmio_we && (mmio_addr == ADDR_ENABLE);
  assign wr_pending = mmio_we && (mmio_addr == ADDR_PENDING);
  assign ack_take   = (state_q == ST_REQ) && int_ack;

  // ---------------------------------------------------------------------------
  // Priority select: lowest enabled pending index wins
  // ---------------------------------------------------------------------------
  assign cand = pending_q & enable_q;

  always_comb begin
    winner = '0;
    // Walk downward so the last hit (lowest index) is the one kept.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = i[IDW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Enable and pending registers
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_d = enable_q;
    if (wr_enable) begin
      enable_d = mmio_wdata[NSRC-1:0];
    end

    // W1C and ack-clear merge; a fresh edge in the same cycle overrides both.
    pend_clr = '0;
    if (wr_pending) begin
      pend_clr = mmio_wdata[NSRC-1:0];
    end
    if (ack_take) begin
      pend_clr[int_id_q] = 1'b1;
    end
    pending_d = (pending_q & ~pend_clr) | rise;
  end

  // ---------------------------------------------------------------------------
  // Request / service FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    int_id_d = int_id_q;
    case (state_q)
      ST_IDLE: begin
        if (cand != '0) begin
          state_d  = ST_REQ;
          int_d    = 1'b1;
          int_id_d = winner;
        end
      end
      ST_REQ: begin
        // int_id stays frozen here; late higher-priority edges or enable changes wait.
        // An int_done arriving with the ack is dropped: only the ack is acted on.
        if (int_ack) begin
          state_d = ST_SERVICE;
          int_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        // Return to IDLE only; any waiting candidate is requested from IDLE one cycle later.
        if (int_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      int_q     <= 1'b0;
      int_id_q  <= '0;
      enable_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      int_id_q  <= int_id_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
    end
  end

  assign Int    = int_q;
  assign int_id = int_id_q;

  // ---------------------------------------------------------------------------
  // MMIO readback
  // ---------------------------------------------------------------------------
  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      ADDR_ENABLE:  mmio_rdata[NSRC-1:0] = enable_q;
      ADDR_PENDING: mmio_rdata[NSRC-1:0] = pending_q;
      ADDR_CLAIM: begin
        mmio_rdata[IDW-1:0]       = int_id_q;
        mmio_rdata[CLAIM_VLD_BIT] = (state_q != ST_IDLE);
      end
      ADDR_STATUS:  mmio_rdata[1:0] = state_q;
      default:      mmio_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Purpose: self-checking bench for int_ctrl: directed scenarios plus randomized rounds checked
//          against a set-based model of pending/enable; expected request IDs go into a queue
//          that a negedge monitor pops whenever Int rises.
// Latency/backpressure: the stimulus waits a bounded number of cycles for each request.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int NSRC = 8;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NSRC-1:0] irq_src;
  logic            Int;
  logic [IDW-1:0]  int_id;
  logic            int_ack;
  logic            int_done;
  logic            mmio_we;
  logic [1:0]      mmio_addr;
  logic [31:0]     mmio_wdata;
  logic [31:0]     mmio_rdata;

  always #5 clk = ~clk;

  int_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_src    (irq_src),
    .Int        (Int),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Scoreboard of source IDs the model expects the DUT to request, in order.
  int exp_q[$];
  int mon_exp;
  logic int_prev = 1'b0;

  // Reference model: plain sets of pending and enabled sources.
  logic [NSRC-1:0] m_en;
  logic [NSRC-1:0] m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every new Int assertion must match the next expected source ID.
  always @(negedge clk) begin
    if (Int === 1'b1 && int_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_request: got Int with id %0d, required no request at %0t",
                 int_id, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("request_id", {29'd0, int_id}, mon_exp);
      end
    end
    int_prev = Int;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    tick();
    mmio_we = 1'b0; mmio_wdata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    mmio_addr = a;
    #1;
    chk(name, mmio_rdata, exp);
  endtask

  task automatic pulse(input logic [NSRC-1:0] p);
    irq_src = p;
    tick();
    irq_src = '0;
  endtask

  task automatic wait_int(input string name);
    for (int i = 0; i < 12 && Int !== 1'b1; i++) tick();
    chk(name, {31'd0, Int}, 32'd1);
  endtask

  task automatic do_ack(input logic with_done);
    int_ack = 1'b1; int_done = with_done;
    tick();
    int_ack = 1'b0; int_done = 1'b0;
  endtask

  task automatic do_done();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  function automatic int lowest(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NSRC-1:0] p, e, w;
    int id;

    rstn = 1'b0; irq_src = '1; int_ack = 1'b0; int_done = 1'b0;
    mmio_we = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    m_en = '0; m_pend = '0;

    // ---------------- reset ----------------
    tick(3);
    chk("reset_int", {31'd0, Int}, 32'd0);
    chk("reset_id", {29'd0, int_id}, 32'd0);
    for (int a = 0; a < 4; a++) rd_chk("reset_mmio", a[1:0], 32'd0);

    // Lines still high at release register as edges, but nothing is enabled.
    rstn = 1'b1;
    tick(6);
    chk("no_request_without_enable", {31'd0, Int}, 32'd0);
    rd_chk("pending_after_release", ADDR_PENDING, 32'hFF);
    irq_src = '0;
    wr(ADDR_PENDING, 32'hFF);
    rd_chk("w1c_all", ADDR_PENDING, 32'h0);
    tick(3);

    // ---------------- basic timing ----------------
    wr(ADDR_ENABLE, 32'h10);
    rd_chk("enable_rw", ADDR_ENABLE, 32'h10);
    exp_q.push_back(4);
    irq_src = 8'h10; tick(); irq_src = '0;         // after edge k
    tick();                                        // after k+1
    rd_chk("basic_pending_k1", ADDR_PENDING, 32'h0);
    tick();                                        // after k+2
    rd_chk("basic_pending_k2", ADDR_PENDING, 32'h10);
    chk("basic_int_k2", {31'd0, Int}, 32'd0);
    tick();                                        // after k+3
    chk("basic_int_k3", {31'd0, Int}, 32'd1);
    chk("basic_id_k3", {29'd0, int_id}, 32'd4);
    rd_chk("basic_status_req", ADDR_STATUS, 32'd1);
    do_ack(1'b0);
    chk("basic_int_after_ack", {31'd0, Int}, 32'd0);
    rd_chk("basic_pending_after_ack", ADDR_PENDING, 32'h0);
    rd_chk("basic_status_service", ADDR_STATUS, 32'd2);
    rd_chk("basic_claim", ADDR_CLAIM, 32'h8000_0004);
    do_done();
    rd_chk("basic_status_idle", ADDR_STATUS, 32'd0);

    // Stray handshakes outside their states are ignored.
    do_ack(1'b0);
    do_done();
    rd_chk("stray_status", ADDR_STATUS, 32'd0);

    // ---------------- priority and freeze ----------------
    wr(ADDR_ENABLE, 32'hFF);
    exp_q.push_back(2);
    pulse(8'h24);
    wait_int("prio_first_int");
    exp_q.push_back(0);
    exp_q.push_back(5);
    pulse(8'h01);
    tick(4);
    chk("freeze_int", {31'd0, Int}, 32'd1);
    chk("freeze_id", {29'd0, int_id}, 32'd2);
    rd_chk("freeze_pending", ADDR_PENDING, 32'h25);
    do_ack(1'b1);
    rd_chk("ack_done_same_cycle", ADDR_STATUS, 32'd2);
    do_done();
    wait_int("prio_second_int");
    do_ack(1'b0); do_done();
    wait_int("prio_third_int");
    do_ack(1'b0); do_done();
    tick(3);
    rd_chk("prio_pending_empty", ADDR_PENDING, 32'h0);
    chk("prio_int_quiet", {31'd0, Int}, 32'd0);

    // ---------------- masked pending and W1C ----------------
    wr(ADDR_ENABLE, 32'h0);
    pulse(8'h08);
    tick(3);
    rd_chk("masked_pending", ADDR_PENDING, 32'h08);
    chk("masked_int", {31'd0, Int}, 32'd0);
    wr(ADDR_PENDING, 32'h08);
    rd_chk("w1c_clear", ADDR_PENDING, 32'h0);
    tick(2);
    irq_src = 8'h08; tick(); irq_src = '0;         // after edge k
    tick();                                        // after k+1
    mmio_we = 1'b1; mmio_addr = ADDR_PENDING; mmio_wdata = 32'h08;
    tick();                                        // W1C lands with the set at k+2
    mmio_we = 1'b0; mmio_wdata = '0;
    rd_chk("set_wins_over_w1c", ADDR_PENDING, 32'h08);
    wr(ADDR_PENDING, 32'h08);

    // ---------------- level hold ----------------
    wr(ADDR_ENABLE, 32'h02);
    exp_q.push_back(1);
    irq_src = 8'h02;
    wait_int("level_int");
    do_ack(1'b0); do_done();
    tick(20);
    chk("level_single_request", {31'd0, Int}, 32'd0);
    rd_chk("level_status", ADDR_STATUS, 32'd0);
    irq_src = '0;
    tick(4);
    exp_q.push_back(1);
    irq_src = 8'h02;
    wait_int("level_rearm_int");
    do_ack(1'b0); do_done();
    irq_src = '0;
    tick(3);

    // ---------------- randomized rounds ----------------
    m_pend = '0;
    rd_chk("rand_start_pending", ADDR_PENDING, 32'h0);
    for (int r = 0; r < 30; r++) begin
      wr(ADDR_ENABLE, 32'h0);
      if ($urandom_range(0, 2) == 0) begin
        w = NSRC'($urandom);
        wr(ADDR_PENDING, {24'd0, w});
        m_pend &= ~w;
      end
      p = NSRC'($urandom & $urandom);
      pulse(p);
      tick(4);
      m_pend |= p;
      // Nothing enabled: stray handshakes must leave the pending set alone.
      do_ack(1'b0);
      do_done();
      rd_chk("rand_pending", ADDR_PENDING, {24'd0, m_pend});
      m_en = NSRC'($urandom);
      wr(ADDR_ENABLE, {24'd0, m_en});
      while ((m_pend & m_en) != '0) begin
        id = lowest(m_pend & m_en);
        exp_q.push_back(id);
        wait_int("rand_int");
        if ($urandom_range(0, 1) == 1) begin
          e = NSRC'($urandom & $urandom);
          pulse(e);
          tick(4);
          m_pend |= e;
        end
        rd_chk("rand_claim", ADDR_CLAIM, 32'h8000_0000 | id);
        do_ack(1'($urandom_range(0, 1)));
        m_pend[id] = 1'b0;
        rd_chk("rand_status_service", ADDR_STATUS, 32'd2);
        do_done();
      end
      tick(2);
      rd_chk("rand_pending_end", ADDR_PENDING, {24'd0, m_pend});
    end

    // ---------------- async reset mid-service ----------------
    wr(ADDR_ENABLE, 32'h0);
    wr(ADDR_PENDING, 32'hFF);
    wr(ADDR_ENABLE, 32'h40);
    exp_q.push_back(6);
    pulse(8'h41);
    wait_int("rst_int");
    do_ack(1'b0);
    rd_chk("rst_status_service", ADDR_STATUS, 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_int_low", {31'd0, Int}, 32'd0);
    chk("rst_id_zero", {29'd0, int_id}, 32'd0);
    rd_chk("rst_status", ADDR_STATUS, 32'd0);
    rd_chk("rst_pending", ADDR_PENDING, 32'h0);
    rd_chk("rst_claim", ADDR_CLAIM, 32'h0);
    rd_chk("rst_enable", ADDR_ENABLE, 32'h0);
    tick();
    rstn = 1'b1;
    tick();
    do_done();
    rd_chk("rst_stray_done", ADDR_STATUS, 32'd0);
    tick(3);
    chk("rst_no_request", {31'd0, Int}, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
